// File: rtl/sbus_arbiter.sv
// Two-initiator round-robin arbiter and transaction sequencer for the serial system bus.
// Define SBUS_ARB_TIMEOUT_EN to build in the stalled-transaction watchdog.
module sbus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] done,
    input  logic [2:0] target_valids,
    output logic [1:0] grant,
    output logic       bus_sel,
    output logic [2:0] release_valids,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        ACTIVE,
        RELEASE
    } state_t;

    if (TIMEOUT_CYCLES < 16) begin : g_timeout_range
        $error("sbus_arbiter: TIMEOUT_CYCLES must be 16 or more");
    end

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       bus_sel_q, bus_sel_d;
    logic [2:0] release_q, release_d;
    logic       busy_q, busy_d;
    logic [2:0] held_q, held_d;
    logic       last_q, last_d;

    logic       winner;
    logic       owner_end;
    logic       expired;
    logic [2:0] close_mask;

    // Only the initiator that owns the bus can end the transaction.
    assign owner_end = done[bus_sel_q] | ~req[bus_sel_q];

`ifdef SBUS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TCNT_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          timeout_q, timeout_d;

    // Expire on the edge where tcnt steps up to TIMEOUT_CYCLES, so the grant
    // is held for exactly TIMEOUT_CYCLES cycles.
    assign expired     = (tcnt_q == TCNT_LAST);
    assign timeout_err = timeout_q;
`else
    assign expired     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        grant_d    = grant_q;
        bus_sel_d  = bus_sel_q;
        release_d  = 3'b000;
        held_d     = held_q;
        last_d     = last_q;
        winner     = 1'b0;
        close_mask = held_q;
`ifdef SBUS_ARB_TIMEOUT_EN
        tcnt_d     = tcnt_q;
        timeout_d  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (|req) begin
                    // Contention goes to whoever was not served last.
                    winner    = (req == 2'b11) ? ~last_q : req[1];
                    grant_d   = winner ? 2'b10 : 2'b01;
                    bus_sel_d = winner;
                    held_d    = 3'b000;
                    state_d   = GRANT;
`ifdef SBUS_ARB_TIMEOUT_EN
                    tcnt_d    = '0;
`endif
                end
            end

            GRANT, ACTIVE: begin
                if ((state_q == GRANT) && (|target_valids)) begin
                    close_mask = target_valids;
                    held_d     = target_valids;
                    state_d    = ACTIVE;
                end
`ifdef SBUS_ARB_TIMEOUT_EN
                if (tcnt_q != TCNT_MAX) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
`endif
                if (owner_end || expired) begin
                    state_d   = RELEASE;
                    grant_d   = 2'b00;
                    release_d = close_mask;
`ifdef SBUS_ARB_TIMEOUT_EN
                    timeout_d = ~owner_end;
`endif
                end
            end

            RELEASE: begin
                grant_d = 2'b00;
                last_d  = bus_sel_q;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            bus_sel_q <= 1'b0;
            release_q <= 3'b000;
            busy_q    <= 1'b0;
            held_q    <= 3'b000;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            bus_sel_q <= bus_sel_d;
            release_q <= release_d;
            busy_q    <= busy_d;
            held_q    <= held_d;
            last_q    <= last_d;
        end
    end

`ifdef SBUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    assign grant          = grant_q;
    assign bus_sel        = bus_sel_q;
    assign release_valids = release_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_sbus_arbiter.sv
// Self-checking bench for sbus_arbiter: transaction-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_sbus_arbiter;

    localparam int T = 32;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] req   = 2'b00;
    logic [1:0] done  = 2'b00;
    logic [2:0] tv    = 3'b000;

    logic [1:0] grant;
    logic       bus_sel;
    logic [2:0] release_valids;
    logic       busy;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;
    int rr_exp[4] = '{1, 2, 1, 2};

    always #5 clk = ~clk;

    sbus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .done          (done),
        .target_valids (tv),
        .grant         (grant),
        .bus_sel       (bus_sel),
        .release_valids(release_valids),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the bus, how long they have held it,
    // which targets they hit, and who is owed the next contended grant.
    int         owner;
    int         served;
    int         prefer;
    int         age;
    bit         releasing;
    bit         got_m;
    logic [2:0] mask_m;
    logic [2:0] rel_m;
    logic [1:0] grant_m;
    logic       sel_m;
    logic       busy_m;
    logic       to_m;

    task automatic model_reset();
        owner     = -1;
        served    = 0;
        prefer    = 0;
        age       = 0;
        releasing = 1'b0;
        got_m     = 1'b0;
        mask_m    = 3'b000;
        rel_m     = 3'b000;
        grant_m   = 2'b00;
        sel_m     = 1'b0;
        busy_m    = 1'b0;
        to_m      = 1'b0;
    endtask

    task automatic model_step();
        bit ended;
        bit timed;
        rel_m = 3'b000;
        to_m  = 1'b0;
        if (releasing) begin
            releasing = 1'b0;
            busy_m    = 1'b0;
            prefer    = 1 - served;
        end else if (owner < 0) begin
            if (req != 2'b00) begin
                if (req == 2'b11) owner = prefer;
                else              owner = req[0] ? 0 : 1;
                grant_m = (owner == 0) ? 2'b01 : 2'b10;
                sel_m   = (owner == 1);
                mask_m  = 3'b000;
                got_m   = 1'b0;
                age     = 0;
                busy_m  = 1'b1;
            end
        end else begin
            age++;
            if (!got_m && tv != 3'b000) begin
                mask_m = tv;
                got_m  = 1'b1;
            end
            ended = done[owner] || !req[owner];
`ifdef SBUS_ARB_TIMEOUT_EN
            timed = (age >= T);
`else
            timed = 1'b0;
`endif
            if (ended || timed) begin
                rel_m     = mask_m;
                to_m      = !ended;
                grant_m   = 2'b00;
                releasing = 1'b1;
                served    = owner;
                owner     = -1;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cyc grant",   32'(grant),          32'(grant_m));
            check("cyc bus_sel", 32'(bus_sel),        32'(sel_m));
            check("cyc release", 32'(release_valids), 32'(rel_m));
            check("cyc busy",    32'(busy),           32'(busy_m));
            check("cyc timeout", 32'(timeout_err),    32'(to_m));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        done  = 2'b00;
        tv    = 3'b000;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        check("rst grant",   32'(grant),          0);
        check("rst bus_sel", 32'(bus_sel),        0);
        check("rst release", 32'(release_valids), 0);
        check("rst busy",    32'(busy),           0);
        check("rst timeout", 32'(timeout_err),    0);

        // Basic transaction: 16 address cycles, target 2, done 8 cycles later.
        req = 2'b01;
        tick(1);
        check("t1 grant latency", 32'(grant), 1);
        check("t1 bus_sel",       32'(bus_sel), 0);
        tick(15);
        tv = 3'b010;
        tick(1);
        tv = 3'b000;
        tick(7);
        done = 2'b01;
        tick(1);
        done = 2'b00;
        req  = 2'b00;
        check("t1 release",    32'(release_valids), 2);
        check("t1 grant drop", 32'(grant), 0);
        check("t1 busy rel",   32'(busy), 1);
        tick(1);
        check("t1 release end", 32'(release_valids), 0);
        check("t1 idle busy",   32'(busy), 0);

        // Round-robin with both requests held, starting from reset.
        do_reset();
        req = 2'b11;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr grant %0d", i), 32'(grant), 32'(rr_exp[i]));
            done = grant;
            tick(1);
            done = 2'b00;
            tick(2);
        end
        check("rr wrap", 32'(grant), 1);
        req = 2'b00;
        tick(1);
        check("rr abort release", 32'(release_valids), 0);
        check("rr abort grant",   32'(grant), 0);
        tick(2);

        // Initiator 1 ends without ever hitting a target.
        req = 2'b10;
        tick(1);
        check("t3 grant",   32'(grant), 2);
        check("t3 bus_sel", 32'(bus_sel), 1);
        tick(3);
        done = 2'b10;
        tick(1);
        done = 2'b00;
        req  = 2'b00;
        check("t3 release", 32'(release_valids), 0);
        check("t3 grant",   32'(grant), 0);
        check("t3 timeout", 32'(timeout_err), 0);
        tick(1);
        check("t3 idle", 32'(busy), 0);
        check("t3 bus_sel hold", 32'(bus_sel), 1);

        // Foreign done ignored in ACTIVE, then req drop releases the mask.
        req = 2'b01;
        tick(1);
        check("t4 grant", 32'(grant), 1);
        tv = 3'b001;
        tick(1);
        tv   = 3'b000;
        done = 2'b10;
        tick(1);
        done = 2'b00;
        check("t4 foreign done", 32'(grant), 1);
        tick(2);
        check("t4 still active", 32'(grant), 1);
        req = 2'b00;
        tick(1);
        check("t4 release", 32'(release_valids), 1);
        check("t4 grant",   32'(grant), 0);
        tick(2);

        // Target decode and done in the same GRANT cycle.
        req = 2'b10;
        tick(1);
        check("t5 grant", 32'(grant), 2);
        tv   = 3'b110;
        done = 2'b10;
        tick(1);
        tv   = 3'b000;
        done = 2'b00;
        req  = 2'b00;
        check("t5 release", 32'(release_valids), 6);
        check("t5 grant",   32'(grant), 0);
        tick(2);

        // done lands on the same edge the watchdog would fire: done wins.
        req = 2'b01;
        tick(1);
        tick(T - 1);
        check("t6 grant before", 32'(grant), 1);
        done = 2'b01;
        tick(1);
        done = 2'b00;
        req  = 2'b00;
        check("t6 timeout", 32'(timeout_err), 0);
        check("t6 release", 32'(release_valids), 0);
        check("t6 grant",   32'(grant), 0);
        tick(2);

        // Stalled transaction.
        req = 2'b01;
        tick(1);
        check("t7 grant", 32'(grant), 1);
        tv = 3'b100;
        tick(1);
        tv = 3'b000;
`ifdef SBUS_ARB_TIMEOUT_EN
        tick(T - 2);
        check("t7 grant held", 32'(grant), 1);
        check("t7 no timeout yet", 32'(timeout_err), 0);
        tick(1);
        check("t7 wd release", 32'(release_valids), 4);
        check("t7 wd timeout", 32'(timeout_err), 1);
        check("t7 wd grant",   32'(grant), 0);
        tick(1);
        check("t7 timeout pulse", 32'(timeout_err), 0);
        req = 2'b00;
        tick(2);
`else
        tick(998);
        check("t7 grant at 1000", 32'(grant), 1);
        req = 2'b00;
        tick(1);
        check("t7 release", 32'(release_valids), 4);
        check("t7 timeout", 32'(timeout_err), 0);
        tick(2);
`endif

        // Asynchronous reset in the middle of an ACTIVE transaction.
        req = 2'b10;
        tick(1);
        tv = 3'b010;
        tick(1);
        tv = 3'b000;
        tick(3);
        check("t8 pre bus_sel", 32'(bus_sel), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t8 grant",   32'(grant), 0);
        check("t8 busy",    32'(busy), 0);
        check("t8 release", 32'(release_valids), 0);
        check("t8 bus_sel", 32'(bus_sel), 0);
        check("t8 timeout", 32'(timeout_err), 0);
        req = 2'b00;
        tick(1);
        rst_n = 1'b1;
        req   = 2'b11;
        tick(1);
        check("t8 first grant", 32'(grant), 1);
        req = 2'b00;
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sbus_arbiter.md
# sbus_arbiter

Two-initiator arbiter and transaction sequencer for the serial system bus. It grants the shared serial bus to one initiator at a time using round-robin, tracks the granted transaction through the address and data phases, and returns the target hold to the address decoder with a one-cycle release strobe when the transaction ends. A watchdog, enabled at compile time, forces release of a transaction that stalls.

## Interface
- TIMEOUT_CYCLES, 1024: maximum number of cycles a grant may remain in GRANT or ACTIVE before forced release. Legal range is 16 or more.
- clk  in  1  bus clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  2  per-initiator bus request, level; bit i is initiator i.
- done  in  2  per-initiator end-of-transaction strobe, one cycle wide.
- target_valids  in  3  target_1/2/3_valid from the address decoder.
- grant  out  2  one-hot grant, registered; reset value 2'b00.
- bus_sel  out  1  initiator index for the bus mux; holds its last value while idle; reset value 0.
- release_valids  out  3  release strobe to the decoder, one cycle wide; reset value 3'b000.
- busy  out  1  high whenever state is not IDLE; reset value 0.
- timeout_err  out  1  one-cycle pulse on a watchdog release; reset value 0.

## Operation
- The FSM has four states: IDLE, GRANT, ACTIVE and RELEASE. The reset state is IDLE.
- Internal state:
  - last_grant has reset value 1, so initiator 0 wins the first arbitration.
  - held_mask is 3 bits wide with reset value 0.
  - tcnt is $clog2(TIMEOUT_CYCLES+1) bits wide.
- IDLE:
  - If any req bit is set, select the winner. With a single request the requester wins. With both requests the initiator that is not last_grant wins.
  - Set grant to the winner's one-hot value, set bus_sel to the winner index, clear held_mask and tcnt, then go to GRANT.
- GRANT (address phase):
  - When any target_valids bit is high, latch it into held_mask and go to ACTIVE.
  - If the granted initiator pulses done or drops req, go to RELEASE. This covers a decode miss or an abort. held_mask is whatever has been latched so far, possibly 0.
- ACTIVE (data phase):
  - When the granted initiator pulses done or drops req, go to RELEASE.
  - target_valids is ignored in this state; held_mask is frozen.
- RELEASE:
  - Drive release_valids = held_mask for exactly this cycle.
  - Set grant to 0, set last_grant to the index of the initiator just served, and go to IDLE.
- done from the non-granted initiator is ignored in every state.
- tcnt increments every cycle in GRANT and ACTIVE and saturates at TIMEOUT_CYCLES.

## Timing
- All outputs are registered, so there is no combinational input-to-output path.
- Grant latency: req is sampled high in IDLE at cycle N, and grant is asserted from cycle N+1.
- grant drops on the cycle the FSM enters RELEASE; release_valids pulses in that same cycle.
- The earliest next grant comes 2 cycles after the previous grant drops (the RELEASE cycle plus the IDLE cycle).
- Minimum transaction is IDLE → GRANT → RELEASE → IDLE, i.e. done arrives in the first GRANT cycle.
- Simultaneous events:
  - target_valids and done together in GRANT: latch held_mask and go directly to RELEASE. The release strobe carries the latched mask.
  - done together with watchdog expiry: done wins and timeout_err stays 0.
  - Both req bits rising in the same IDLE cycle: resolved by round-robin.
- Reset asserted mid-transaction: all outputs and internal state go to their reset values immediately. No release strobe is issued; the decoder is reset by the same rst_n.

## Configuration
- SBUS_ARB_TIMEOUT_EN defined:
  - When tcnt reaches TIMEOUT_CYCLES in GRANT or ACTIVE with no done or req drop, the FSM goes to RELEASE.
  - release_valids = held_mask, and timeout_err pulses high for the same cycle.
- SBUS_ARB_TIMEOUT_EN undefined:
  - tcnt and the watchdog logic are absent, and timeout_err is tied to 0.
  - A transaction ends only on done or on the granted initiator dropping req.

## Test plan
- Reset, then req=2'b01, 16 address cycles, then target_valids=3'b010, then done[0] 8 cycles later → expect:
  - grant=2'b01 one cycle after req;
  - held_mask=3'b010;
  - release_valids=3'b010 for one cycle;
  - grant=0 in that same cycle.
- req=2'b11 held continuously over 4 transactions → grants alternate 01, 10, 01, 10, starting with initiator 0 after reset.
- Granted initiator 1 pulses done with target_valids never high → release_valids=3'b000, FSM returns to IDLE, no timeout_err.
- Granted initiator 0 in ACTIVE while done[1] pulses → ignored, grant stays 2'b01. Then req[0] is dropped → RELEASE with the latched mask.
- With SBUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=32: grant, target_valids=3'b100, no done → after 32 cycles, release_valids=3'b100 and timeout_err=1 for one cycle. Without the macro, grant is still held at cycle 1000.
- rst_n pulsed low while in ACTIVE → asynchronously grant=0, busy=0, release_valids=0, bus_sel=0. After reset, initiator 0 is granted first.
